// File: rtl/mips_mc_pkg.sv
// Shared types, opcode/funct encodings and the ALU function for the multicycle MIPS core.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
        S_RTYPEWB, S_ADDIEX, S_ORIEX, S_IWB, S_BREX, S_JEX, S_HALT
    } state_t;

    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] SRCB_B     = 3'd0;
    localparam logic [2:0] SRCB_FOUR  = 3'd1;
    localparam logic [2:0] SRCB_SEXT  = 3'd2;
    localparam logic [2:0] SRCB_SEXT2 = 3'd3;
    localparam logic [2:0] SRCB_ZEXT  = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       mdr_we;
        logic       ab_we;
        logic       aluout_we;
        logic       pc_we;
        logic       alusrca;
        logic       rf_we;
        logic       regdst;
        logic       memtoreg;
        logic       halted;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    function automatic logic [31:0] alu_eval(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        case (f)
            ALU_AND: alu_eval = a & b;
            ALU_OR:  alu_eval = a | b;
            ALU_ADD: alu_eval = a + b;
            ALU_SUB: alu_eval = a - b;
            ALU_SLT: alu_eval = {31'b0, $signed(a) < $signed(b)};
            default: alu_eval = '0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Unified instruction/data memory port with a ready handshake.
interface mips_mc_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM and ALU decode; emits register enables and datapath mux selects.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    input  logic       i_zero,
    output ctrl_t      o_ctrl
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_rfunct;
    logic       w_rfunct_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_rfunct_ok = 1'b1;
        case (i_funct)
            FN_ADD:  w_rfunct = ALU_ADD;
            FN_SUB:  w_rfunct = ALU_SUB;
            FN_AND:  w_rfunct = ALU_AND;
            FN_OR:   w_rfunct = ALU_OR;
            FN_SLT:  w_rfunct = ALU_SLT;
            default: begin
                w_rfunct    = ALU_ADD;
                w_rfunct_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next          = r_state;
        o_ctrl          = '0;
        o_ctrl.alu_ctrl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.alusrcb = SRCB_FOUR;
                if (i_mem_ready) begin
                    o_ctrl.ir_we = 1'b1;
                    o_ctrl.pc_we = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                o_ctrl.ab_we     = 1'b1;
                o_ctrl.aluout_we = 1'b1;
                o_ctrl.alusrcb   = SRCB_SEXT2;
                case (i_op)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = w_rfunct_ok ? S_RTYPEEX : S_HALT;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_ORI:         w_next = S_ORIEX;
                    OP_BEQ, OP_BNE: w_next = S_BREX;
                    OP_J:           w_next = S_JEX;
                    default:        w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alusrcb   = SRCB_SEXT;
                o_ctrl.aluout_we = 1'b1;
                w_next           = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.iord    = 1'b1;
                if (i_mem_ready) begin
                    o_ctrl.mdr_we = 1'b1;
                    w_next        = S_MEMWB;
                end
            end
            S_MEMWB: begin
                o_ctrl.rf_we    = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                w_next          = S_FETCH;
            end
            S_MEMWR: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.mem_we  = 1'b1;
                o_ctrl.iord    = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_RTYPEEX: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alu_ctrl  = w_rfunct;
                o_ctrl.aluout_we = 1'b1;
                w_next           = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                o_ctrl.rf_we  = 1'b1;
                o_ctrl.regdst = 1'b1;
                w_next        = S_FETCH;
            end
            S_ADDIEX: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alusrcb   = SRCB_SEXT;
                o_ctrl.aluout_we = 1'b1;
                w_next           = S_IWB;
            end
            S_ORIEX: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alusrcb   = SRCB_ZEXT;
                o_ctrl.alu_ctrl  = ALU_OR;
                o_ctrl.aluout_we = 1'b1;
                w_next           = S_IWB;
            end
            S_IWB: begin
                o_ctrl.rf_we = 1'b1;
                w_next       = S_FETCH;
            end
            S_BREX: begin
                // ALUOut already holds the target computed during DECODE
                o_ctrl.alusrca  = 1'b1;
                o_ctrl.alu_ctrl = ALU_SUB;
                o_ctrl.pcsrc    = PCSRC_ALUOUT;
                o_ctrl.pc_we    = (i_op == OP_BEQ) ? i_zero : ~i_zero;
                w_next          = S_FETCH;
            end
            S_JEX: begin
                o_ctrl.pc_we = 1'b1;
                o_ctrl.pcsrc = PCSRC_JUMP;
                w_next       = S_FETCH;
            end
            S_HALT:  o_ctrl.halted = 1'b1;
            default: w_next = S_HALT;
        endcase
    end

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: shared ALU, unified memory port, FSM-sequenced datapath.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
)(
    input  logic              clk,
    input  logic              reset_n,
    mips_mc_if.master         mem,
    output logic              halted,
    output logic [31:0]       pc,
    input  logic [4:0]        dbg_ra,
    output logic [DATA_W-1:0] dbg_rd
);

    if (DATA_W != 32) begin : g_bad_width
        $error("mips_mc_core: DATA_W must be 32");
    end

    ctrl_t             w_ctrl;
    logic [31:0]       r_pc, r_ir;
    logic [DATA_W-1:0] r_mdr, r_a, r_b, r_aluout;
    logic [DATA_W-1:0] r_rf [32];
    logic [31:0]       w_sext, w_srca, w_srcb, w_alu_y, w_pc_next;
    logic [DATA_W-1:0] w_rd1, w_rd2, w_wd;
    logic [4:0]        w_wa;
    logic              w_zero;

    mips_mc_ctrl u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_op        (r_ir[31:26]),
        .i_funct     (r_ir[5:0]),
        .i_mem_ready (mem.mem_ready),
        .i_zero      (w_zero),
        .o_ctrl      (w_ctrl)
    );

    assign w_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_srca = w_ctrl.alusrca ? r_a : r_pc;

    always_comb begin
        case (w_ctrl.alusrcb)
            SRCB_FOUR:  w_srcb = 32'd4;
            SRCB_SEXT:  w_srcb = w_sext;
            SRCB_SEXT2: w_srcb = {w_sext[29:0], 2'b00};
            SRCB_ZEXT:  w_srcb = {16'b0, r_ir[15:0]};
            default:    w_srcb = r_b;
        endcase
    end

    assign w_alu_y = alu_eval(w_ctrl.alu_ctrl, w_srca, w_srcb);
    assign w_zero  = (w_alu_y == '0);

    always_comb begin
        case (w_ctrl.pcsrc)
            PCSRC_ALUOUT: w_pc_next = r_aluout;
            PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            default:      w_pc_next = w_alu_y;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (w_ctrl.pc_we)     r_pc     <= w_pc_next;
            if (w_ctrl.ir_we)     r_ir     <= mem.mem_rdata;
            if (w_ctrl.mdr_we)    r_mdr    <= mem.mem_rdata;
            if (w_ctrl.aluout_we) r_aluout <= w_alu_y;
            if (w_ctrl.ab_we) begin
                r_a <= w_rd1;
                r_b <= w_rd2;
            end
        end
    end

    // Register file is deliberately not reset; $0 is forced to zero on every read port
    assign w_wa = w_ctrl.regdst ? r_ir[15:11] : r_ir[20:16];
    assign w_wd = w_ctrl.memtoreg ? r_mdr : r_aluout;

    always_ff @(posedge clk) begin
        if (w_ctrl.rf_we && (w_wa != 5'd0)) r_rf[w_wa] <= w_wd;
    end

    assign w_rd1  = (r_ir[25:21] == 5'd0) ? '0 : r_rf[r_ir[25:21]];
    assign w_rd2  = (r_ir[20:16] == 5'd0) ? '0 : r_rf[r_ir[20:16]];
    assign dbg_rd = (dbg_ra == 5'd0) ? '0 : r_rf[dbg_ra];

    // Request and write strobe fall the instant reset is asserted, even mid-access
    assign mem.mem_req   = w_ctrl.mem_req & reset_n;
    assign mem.mem_we    = w_ctrl.mem_we & reset_n;
    assign mem.mem_addr  = w_ctrl.iord ? r_aluout : r_pc;
    assign mem.mem_wdata = r_b;
    assign halted        = w_ctrl.halted;
    assign pc            = r_pc;

endmodule

// File: tb/tb_mips_mc_core.sv
// Scoreboard bench for mips_mc_core: expected bus transactions queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_mips_mc_core;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    localparam logic [31:0] PROG [16] = '{
        32'h20020005, 32'h34438000, 32'hAC030040, 32'h8C040040,
        32'h00420020, 32'h2005FFFF, 32'h20060001, 32'h00A6382A,
        32'h00064022, 32'h10420002, 32'hFC000000, 32'hFC000000,
        32'h14420005, 32'h00624824, 32'h00435025, 32'h08000040};

    // Expected bus stream for one pass, with zero-wait completion cycles
    localparam logic [31:0] EXP_ADDR [17] = '{
        32'h100, 32'h104, 32'h108, 32'h040, 32'h10C, 32'h040, 32'h110, 32'h114, 32'h118,
        32'h11C, 32'h120, 32'h124, 32'h130, 32'h134, 32'h138, 32'h13C, 32'h100};
    localparam int EXP_CYC [17] = '{0, 4, 8, 11, 12, 15, 17, 21, 25, 29, 33, 37, 40, 43, 47, 51, 54};

    localparam logic [4:0]  REG_IDX [10] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
    localparam logic [31:0] REG_EXP [10] = '{32'h0, 32'h5, 32'h8005, 32'h8005, 32'hFFFFFFFF,
                                             32'h1, 32'h1, 32'hFFFFFFFF, 32'h5, 32'h8005};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        halted;
    logic [31:0] pc;
    logic [4:0]  dbg_ra;
    logic [31:0] dbg_rd;

    mips_mc_if mem_if ();

    mips_mc_core #(.RESET_PC(RPC), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mem     (mem_if),
        .halted  (halted),
        .pc      (pc),
        .dbg_ra  (dbg_ra),
        .dbg_rd  (dbg_rd)
    );

    always #5 clk = ~clk;

    // Memory model: word array, ready after `waits` stall cycles
    logic [31:0] mem_arr [256];
    int          waits;
    int          wcnt;
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;
    int          cyc;

    assign mem_if.mem_ready = mem_if.mem_req && (wcnt == waits);
    assign mem_if.mem_rdata = mem_arr[mem_if.mem_addr[9:2]];

    always @(posedge clk) begin
        if (ld_en) mem_arr[ld_addr[9:2]] <= ld_data;
        if (!reset_n) wcnt <= 0;
        else if (mem_if.mem_req) begin
            if (mem_if.mem_ready) begin
                wcnt <= 0;
                if (mem_if.mem_we) mem_arr[mem_if.mem_addr[9:2]] <= mem_if.mem_wdata;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    txn_t        sb [$];
    string       q_name [$];
    logic [31:0] q_got [$];
    logic [31:0] q_exp [$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        q_name.push_back(name);
        q_got.push_back(got);
        q_exp.push_back(exp);
    endtask

    // Monitor: the only process that compares and steps the counters
    always @(negedge clk) begin : monitor
        string       nm;
        logic [31:0] g, x;
        txn_t        e;
        logic        ok;
        logic        prev_wait;
        logic        prev_we;
        logic [31:0] prev_addr;
        while (q_name.size() > 0) begin
            nm = q_name.pop_front();
            g  = q_got.pop_front();
            x  = q_exp.pop_front();
            n_checks++;
            if (g === x) n_pass++;
            else $display("FAIL %s: got %h expected %h", nm, g, x);
        end
        if (!reset_n) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                n_checks++;
                if (mem_if.mem_req === 1'b1 && mem_if.mem_addr === prev_addr && mem_if.mem_we === prev_we)
                    n_pass++;
                else
                    $display("FAIL hold_stable: got req=%b we=%b addr=%h required req=1 we=%b addr=%h",
                             mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, prev_we, prev_addr);
            end
            if (mem_if.mem_req && mem_if.mem_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_txn: got we=%b addr=%h cyc=%0d required none",
                             mem_if.mem_we, mem_if.mem_addr, cyc);
                end else begin
                    e  = sb.pop_front();
                    ok = (mem_if.mem_we === e.we) && (mem_if.mem_addr === e.addr) && (cyc == e.cyc) &&
                         (!e.we || mem_if.mem_wdata === e.wdata);
                    $display("txn cyc=%0d we=%b addr=%h wdata=%h", cyc, mem_if.mem_we, mem_if.mem_addr,
                             mem_if.mem_wdata);
                    if (ok) n_pass++;
                    else $display("FAIL txn: got we=%b addr=%h wdata=%h cyc=%0d required we=%b addr=%h wdata=%h cyc=%0d",
                                  mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, cyc,
                                  e.we, e.addr, e.wdata, e.cyc);
                end
            end
            prev_wait = mem_if.mem_req && !mem_if.mem_ready;
            prev_addr = mem_if.mem_addr;
            prev_we   = mem_if.mem_we;
        end
    end

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) load_word(RPC + 32'(4 * i), PROG[i]);
    endtask

    task automatic push_expected(input int w, input int count);
        txn_t t;
        for (int k = 0; k < count; k++) begin
            t.we    = (k == 3);
            t.addr  = EXP_ADDR[k];
            t.wdata = (k == 3) ? 32'h8005 : 32'h0;
            t.cyc   = EXP_CYC[k] + w * (k + 1);
            sb.push_back(t);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 10; i++) begin
            dbg_ra = REG_IDX[i];
            #1;
            chk($sformatf("%s_r%0d", tag, REG_IDX[i]), dbg_rd, REG_EXP[i]);
        end
    endtask

    // Caller holds reset with memory loaded; releases reset and runs one full pass to HALT
    task automatic run_program(input int w, input logic check_early);
        int i;
        push_expected(w, 17);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("pc_after_1", pc, (w == 0) ? RPC + 32'd4 : RPC);
        if (check_early) begin
            repeat (7) @(negedge clk);
            dbg_ra = 5'd2; #1; chk("early_r2", dbg_rd, 32'h5);
            dbg_ra = 5'd3; #1; chk("early_r3", dbg_rd, 32'h8005);
        end
        for (i = 0; i < 2000 && pc != 32'h140; i++) @(negedge clk);
        chk("reach_j", pc, 32'h140);
        // Jump lands on RESET_PC; make that fetch a halt so the pass terminates
        load_word(RPC, HALT);
        for (i = 0; i < 2000 && !halted; i++) @(negedge clk);
        chk("halted", {31'b0, halted}, 32'h1);
        chk("halt_cyc", cyc, 32'(56 + w * 17));
        chk("halt_pc", pc, RPC + 32'd4);
        repeat (4) @(negedge clk);
        chk("halt_req", {31'b0, mem_if.mem_req}, 32'h0);
        chk("sb_drained", sb.size(), 32'h0);
    endtask

    initial begin
        int i;
        reset_n = 1'b0;
        waits   = 0;
        dbg_ra  = 5'd0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        load_prog();
        load_word(32'h40, 32'h0);
        chk("rst_pc", pc, RPC);
        chk("rst_req", {31'b0, mem_if.mem_req}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);

        run_program(0, 1'b1);
        check_regs("zw");
        chk("zw_mem40", mem_arr[16], 32'h8005);

        reset_n = 1'b0;
        load_prog();
        load_word(32'h40, 32'h0);
        waits = 3;
        run_program(3, 1'b0);
        check_regs("ws");
        chk("ws_mem40", mem_arr[16], 32'h8005);

        // Reset asserted while the store is waiting for ready
        reset_n = 1'b0;
        load_prog();
        load_word(32'h40, 32'hDEADBEEF);
        push_expected(3, 3);
        @(negedge clk);
        reset_n = 1'b1;
        for (i = 0; i < 500 && !(mem_if.mem_req && mem_if.mem_we); i++) @(negedge clk);
        chk("reach_memwr", {31'b0, mem_if.mem_we}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_drop_req", {31'b0, mem_if.mem_req}, 32'h0);
        chk("rst_drop_we", {31'b0, mem_if.mem_we}, 32'h0);
        chk("rst_pc_again", pc, RPC);
        chk("rst_sb_drained", sb.size(), 32'h0);
        repeat (2) @(negedge clk);
        chk("no_write", mem_arr[16], 32'hDEADBEEF);
        waits = 0;
        run_program(0, 1'b0);
        check_regs("rs");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
Parametrised multicycle successor to the single-cycle MIPS datapath: one shared ALU, one unified memory port, and an internal control FSM that sequences each instruction over 3–5 states.
- Memory port has a ready handshake, so arbitrary wait states are tolerated.
- Instruction set: lw, sw, add, sub, and, or, slt, addi, ori (zero-extended immediate), beq, bne, j.
- Any other opcode/funct halts the core.
- Sits between the lab top level and a unified instruction/data memory model.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DATA_W, 32, datapath/register width; only 32 is legal, elaborate-time assertion otherwise

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
mem_req  out  1  memory access request
mem_we  out  1  1 = write, valid with mem_req
mem_addr  out  32  byte address, word aligned
mem_wdata  out  32  store data
mem_rdata  in  32  load/fetch data, valid when mem_ready
mem_ready  in  1  access completes this cycle; may be combinational from mem_req
halted  out  1  illegal instruction seen; core frozen
pc  out  32  current PC register
dbg_ra  in  5  debug register read address
dbg_rd  out  32  combinational read of register dbg_ra ($0 reads 0)

Behaviour:
Reset (reset_n low, asynchronous):
- PC=RESET_PC, state=FETCH.
- IR, A, B, ALUOut, MDR = 0.
- mem_req=0 while in reset, halted=0.
- Register file contents are not reset.

Architectural registers, updated only on the edges stated below:
- PC, IR, MDR, A, B, ALUOut.
- 32x32 register file, $0 hard-wired to 0, synchronous write.

FSM states and actions:
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Hold until mem_ready. On the ready edge: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE: A<=RF[rs], B<=RF[rt], ALUOut<=PC+(signext(imm)<<2). Next state by opcode; unknown opcode or R-funct goes to HALT.
- MEMADR: ALUOut<=A+signext(imm). Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, mem_addr=ALUOut. Hold until mem_ready; then MDR<=mem_rdata, go to MEMWB.
- MEMWB: RF[rt]<=MDR, go to FETCH.
- MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. Hold until mem_ready, then go to FETCH.
- RTYPEEX: ALUOut<=A op B, go to RTYPEWB.
- RTYPEWB: RF[rd]<=ALUOut, go to FETCH.
- ADDIEX: ALUOut<=A+signext(imm), go to IWB.
- ORIEX: ALUOut<=A | {16'b0,imm}, go to IWB.
- IWB: RF[rt]<=ALUOut, go to FETCH.
- BREX: ALU computes A−B.
  - beq with zero=1: PC<=ALUOut.
  - bne with zero=0: PC<=ALUOut.
  - Otherwise PC is unchanged.
  - Go to FETCH.
- JEX: PC<={PC[31:28], IR[25:0], 2'b00}, go to FETCH.
- HALT: terminal. halted=1, mem_req=0, no further state changes until reset.

Rules and boundary conditions:
- mem_req, mem_we and mem_addr are held stable while waiting for mem_ready.
- mem_ready is ignored when mem_req=0.
- Zero-wait cycle counts: lw 5, sw/R/addi/ori 4, beq/bne/j 3.
- Each wait cycle adds one cycle.
- Writes to $0 are discarded.
- slt is signed. Arithmetic overflow wraps with no trap.
- PC+4 wraps modulo 2^32.
- Branch target uses the already-incremented PC.
- reset_n asserted during a pending access drops mem_req in the same cycle (asynchronous), with no write side-effects.

Decomposition:
- Package mips_mc_pkg holds:
  - state_t enum
  - opcode constants: LW 6'h23, SW 6'h2b, RTYPE 0, ADDI 6'h08, ORI 6'h0d, BEQ 6'h04, BNE 6'h05, J 6'h02
  - funct constants
  - 3-bit alucontrol codes, matching the existing alu
- Sub-module mips_mc_ctrl: the FSM plus ALU decode, emitting enables and mux selects.
- Top level instantiates mips_mc_ctrl, the existing alu and adder/mux primitives, and a register file with the debug port.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory → first mem_addr=0x100; pc=0x104 after one cycle.
- addi $2,$0,5 (0x20020005), then ori $3,$2,0x8000 → after 8 cycles dbg_rd($2)=5, $3=0x00008005; sw/lw round-trip of $3 via address 0x40 returns 0x8005.
- add $0,$2,$2 → $0 stays 0. slt with -1 vs 1 gives 1. sub 0−1 gives 0xFFFFFFFF.
- beq taken (equal regs, offset +2) → pc advances by 12. bne with equal regs → pc advances by 4. j 0x0000040 → pc=0x100 (upper bits from PC).
- Memory inserts 3 wait cycles on every access → lw takes 11 cycles; mem_addr/mem_we stay stable throughout; final result identical to the zero-wait run.
- Opcode 0x3F → halted=1 after DECODE; mem_req stays 0. reset_n pulse mid-MEMWR → mem_req drops immediately and restart occurs at RESET_PC.
